// File: rtl/ac3_acc_quant.sv
// Accumulator and quantizer around the AC3 adder. It sums accepted operands,
// right-shifts the total, saturates it to Pa bits and hands it off on valid/ready.
module ac3_acc_quant #(
  parameter int M   = 16,
  parameter int Pa  = 8,
  parameter int Pw  = 4,
  parameter int MNO = 288,
  localparam int W  = $clog2(M) + Pa + Pw + $clog2(MNO),
  localparam int NW = $clog2(MNO + 1),
  localparam int SW = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [NW-1:0] n_ops,
  input  logic [SW-1:0] q_shift,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  sum_in,
  output logic [W-1:0]  acc_out,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [Pa-1:0] out_data,
  output logic          busy
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; valid is never withdrawn and data stays stable until then.

  typedef enum logic [1:0] {IDLE, ACC, SHIFT, OUT} state_t;

  state_t        state, state_nxt;
  logic [NW-1:0] op_cnt;
  logic [SW-1:0] sh_cnt;
  logic          accept;

  function automatic logic [Pa-1:0] sat(input logic [W-1:0] x);
    return (|x[W-1:Pa]) ? {Pa{1'b1}} : x[Pa-1:0];
  endfunction

  assign in_ready  = (state == ACC);
  assign out_valid = (state == OUT);
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (n_ops != '0)        state_nxt = ACC;
          else if (q_shift != '0) state_nxt = SHIFT;
          else                    state_nxt = OUT;
        end
      end
      ACC: begin
        if (accept && op_cnt == NW'(1))
          state_nxt = (sh_cnt != '0) ? SHIFT : OUT;
      end
      SHIFT: begin
        if (sh_cnt == SW'(1)) state_nxt = OUT;
      end
      OUT: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath; out_data is loaded on whichever edge moves the FSM into OUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_out  <= '0;
      op_cnt   <= '0;
      sh_cnt   <= '0;
      out_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc_out <= '0;
            op_cnt  <= n_ops;
            sh_cnt  <= q_shift;
            if (n_ops == '0 && q_shift == '0) out_data <= '0;
          end
        end
        ACC: begin
          if (accept) begin
            acc_out <= sum_in;
            op_cnt  <= op_cnt - NW'(1);
            if (op_cnt == NW'(1) && sh_cnt == '0) out_data <= sat(sum_in);
          end
        end
        SHIFT: begin
          acc_out <= acc_out >> 1;
          sh_cnt  <= sh_cnt - SW'(1);
          if (sh_cnt == SW'(1)) out_data <= sat(acc_out >> 1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ac3_acc_quant.sv
// Directed and randomized bench for ac3_acc_quant against an arithmetic
// reference model (running sum, shift, saturate).
module tb_ac3_acc_quant;

  localparam int W  = 25;
  localparam int Pa = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [8:0]    n_ops = '0;
  logic [4:0]    q_shift = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  sum_in = '0;
  logic [W-1:0]  acc_out;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [Pa-1:0] out_data;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0]  op_q[$];
  logic [Pa-1:0] exp_q[$];

  ac3_acc_quant dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_ops(n_ops), .q_shift(q_shift),
    .in_valid(in_valid), .in_ready(in_ready), .sum_in(sum_in), .acc_out(acc_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference result: total of all operands mod 2^W, shifted, saturated.
  function automatic logic [Pa-1:0] model_result(input int qs);
    logic [W-1:0] total = '0;
    logic [W-1:0] shifted;
    foreach (op_q[i]) total = total + op_q[i];
    shifted = total >> qs;
    return (shifted > W'(255)) ? 8'd255 : shifted[Pa-1:0];
  endfunction

  // One full transaction using the operands queued in op_q.
  task automatic run_txn(input int qs, input int gap_max, input int stall,
                         input bit noise, input bit start_in_out);
    int           n = op_q.size();
    logic [W-1:0] acc_m = '0;
    logic [Pa-1:0] e;
    exp_q.push_back(model_result(qs));
    start = 1'b1; n_ops = 9'(n); q_shift = 5'(qs);
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("acc_cleared", acc_out, 0);
    if (n == 0) chk("no_ready_when_n0", in_ready, 0);
    for (int k = 0; k < n; k++) begin
      int gap = $urandom_range(0, gap_max);
      repeat (gap) begin
        chk("ready_during_gap", in_ready, 1);
        tick();
        chk("acc_stall", acc_out, acc_m);
      end
      in_valid = 1'b1;
      sum_in = acc_m + op_q[k];
      chk("ready_acc", in_ready, 1);
      tick();
      in_valid = 1'b0;
      sum_in = W'($urandom);
      acc_m = acc_m + op_q[k];
      chk("acc_sum", acc_out, acc_m);
    end
    if (noise) begin in_valid = 1'b1; sum_in = W'($urandom); end
    for (int i = 0; i < qs; i++) begin
      chk("no_valid_in_shift", out_valid, 0);
      tick();
      acc_m = acc_m >> 1;
      chk("acc_shift", acc_out, acc_m);
    end
    in_valid = 1'b0;
    chk("out_valid_latency", out_valid, 1);
    e = exp_q.pop_front();
    chk("out_data", out_data, e);
    repeat (stall) begin
      start = start_in_out ? 1'b1 : 1'($urandom_range(0, 1));
      tick();
      start = 1'b0;
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, e);
      chk("hold_acc", acc_out, acc_m);
    end
    out_ready = 1'b1;
    start = start_in_out;
    tick();
    out_ready = 1'b0;
    start = 1'b0;
    chk("valid_dropped", out_valid, 0);
    chk("idle_after_hs", busy, 0);
    chk("data_kept", out_data, e);
    tick();
    chk("start_at_hs_ignored", busy, 0);
    op_q.delete();
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_acc", acc_out, 0);
    chk("rst_data", out_data, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();

    op_q = '{W'(10), W'(20), W'(30)};
    run_txn(2, 0, 0, 1'b0, 1'b0);

    op_q = '{W'(1000), W'(1000)};
    run_txn(1, 0, 0, 1'b0, 1'b0);

    run_txn(3, 0, 0, 1'b1, 1'b0);

    op_q = '{W'(77), W'(99)};
    run_txn(0, 4, 5, 1'b0, 1'b1);

    op_q = '{W'(33554431), W'(1)};
    run_txn(0, 0, 0, 1'b0, 1'b0);

    // Reset in the middle of accumulation.
    start = 1'b1; n_ops = 9'd5; q_shift = 5'd0;
    tick();
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      sum_in = W'(k + 100);
      tick();
    end
    in_valid = 1'b0;
    chk("acc_before_rst", acc_out, 101);
    rst_n = 1'b0;
    #1;
    chk("midrst_acc", acc_out, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_ready", in_ready, 0);
    tick();
    rst_n = 1'b1;
    tick();
    op_q = '{W'(7)};
    run_txn(0, 0, 0, 1'b0, 1'b0);

    for (int t = 0; t < 25; t++) begin
      int n  = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 8);
      int qs = $urandom_range(0, 31);
      bit big = 1'($urandom_range(0, 1));
      for (int k = 0; k < n; k++)
        op_q.push_back(big ? W'($urandom) : W'($urandom_range(0, 300)));
      run_txn(qs, 2, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
